rgb_tx_serializer: RTL and testbench
====================================

Name: rgb_tx_serializer

Overview:
Transmit-side counterpart of the byte-to-RGB assembler. It accepts processed 24-bit RGB pixels as single-cycle valid pulses and buffers them in a small pixel FIFO. It serializes each pixel into three bytes (R, G, B) and issues paced one-cycle send strobes to uart_tx. It sits between the pixel processing stage and uart_tx, and absorbs pixel bursts that arrive faster than the UART line rate.

Parameters:
ADDR_W, 2, FIFO address width; depth = 2^ADDR_W pixels (default 4).
BYTE_GAP, 16'd5000, idle clocks after each send strobe; must be at least 1 and must exceed the uart_tx frame time in clocks.

Ports:
sys_clk  input  1  system clock, rising-edge.
sys_rst_n  input  1  asynchronous active-low reset.
data_in_valid  input  1  one-cycle pixel-valid strobe.
r_data_in  input  8  red component, sampled when data_in_valid=1.
g_data_in  input  8  green component.
b_data_in  input  8  blue component.
data_out  output  8  byte to uart_tx din; registered; holds its value between strobes.
data_out_ready  output  1  one-cycle send_start strobe to uart_tx.
fifo_level  output  ADDR_W+1  number of pixels stored.
busy  output  1  high whenever FSM is not IDLE or fifo_level is not 0.
overflow  output  1  sticky flag: a pixel was dropped because the FIFO was full.

Behaviour:
- Reset (async, sys_rst_n=0): FIFO empty, fifo_level=0, data_out=8'd0, data_out_ready=0, overflow=0, busy=0, FSM=IDLE, byte index=0, gap counter=0.
  - Reset mid-transmission aborts the current pixel immediately.
  - Buffered pixels are discarded.
- FIFO: 24-bit entries {R,G,B}. Write occurs when data_in_valid=1 and either fifo_level<2^ADDR_W, or fifo_level is full and a pop happens in the same cycle.
  - Write while full with no pop: the pixel is dropped and overflow is set to 1. overflow stays 1 until reset.
  - Simultaneous write and pop: level is unchanged and both operations occur.
  - Read and write pointers wrap modulo 2^ADDR_W.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if fifo_level!=0, pop the head pixel into a 24-bit holding register, set byte index=0, go to SEND. Otherwise stay in IDLE.
  - SEND (1 cycle): data_out <= byte[index] (0=R, 1=G, 2=B). data_out_ready=1 for this cycle only. Clear gap counter. Go to GAP.
  - GAP: increment counter each cycle. When counter==BYTE_GAP-1:
    - if index==2, go to IDLE;
    - otherwise index++ and go to SEND.
- Timing:
  - Pixel written in cycle t (FIFO previously empty, FSM in IDLE): pop in cycle t+1; R strobe in t+2.
  - G strobe at t+3+BYTE_GAP; B strobe at t+4+2*BYTE_GAP.
  - Strobe spacing within a pixel is BYTE_GAP+1 cycles.
  - B strobe to next pixel's R strobe is BYTE_GAP+2 cycles (one IDLE cycle).
- data_out and data_out_ready are registered and change only on the SEND transition. No byte is ever issued twice. Strobes are never back-to-back.
- Pixels are issued in arrival order. Input writes continue normally during SEND and GAP.
- Arithmetic: gap counter is 16 bits unsigned. fifo_level ranges 0..2^ADDR_W.

Test Plan:
1. Reset, then one pixel (R=8'h12, G=8'h34, B=8'h56) with BYTE_GAP=4.
   -> Strobes at t+2, t+7, t+12 with data_out 12, 34, 56.
   -> busy falls 6 cycles after the last strobe (4 GAP cycles plus 1 IDLE cycle, registered).
2. Burst of 4 pixels on consecutive cycles, ADDR_W=2, BYTE_GAP=4.
   -> 12 strobes in pixel order, spacing 5 within a pixel and 6 between pixels.
   -> fifo_level peaks at 3 (one pixel is popped on the cycle after the first write).
   -> overflow stays 0.
3. Burst of 7 pixels on consecutive cycles.
   -> 5 pixels accepted (4 buffered plus the popped pixel); pixels 6 and 7 dropped.
   -> overflow=1 and remains 1 afterwards.
   -> Only the first 5 pixels appear on data_out.
4. FIFO full and a write arrives in the same cycle the FSM pops.
   -> Write accepted, fifo_level stays 4, overflow stays 0.
5. Assert sys_rst_n=0 during the GAP after the G strobe.
   -> All outputs return to reset values asynchronously. The B byte is never strobed.
   -> A new pixel sent after reset produces a normal 3-byte sequence.

Source files
------------

// File: rtl/rgb_tx_serializer.sv
// Purpose: buffers 24-bit RGB pixels and serializes each into paced R,G,B byte strobes for uart_tx.
// Latency: first pixel into an idle block -> R strobe two cycles later; later bytes every BYTE_GAP+1 cycles.
// Backpressure: none upstream; a pixel arriving while the FIFO is full (and nothing pops) is dropped, overflow latches.
//
// Ports:
//   sys_clk, sys_rst_n            : rising-edge clock, asynchronous active-low reset
//   data_in_valid                 : one-cycle pixel strobe, samples r/g/b_data_in
//   r_data_in, g_data_in, b_data_in : pixel components
//   data_out, data_out_ready      : registered byte and one-cycle send_start strobe to uart_tx
//   fifo_level                    : pixels currently buffered (0..2^ADDR_W)
//   busy                          : registered; FSM active or pixels pending
//   overflow                      : sticky pixel-drop flag, cleared only by reset

module rgb_tx_serializer #(
  parameter int          ADDR_W   = 2,
  parameter logic [15:0] BYTE_GAP = 16'd5000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              data_in_valid,
  input  logic [7:0]        r_data_in,
  input  logic [7:0]        g_data_in,
  input  logic [7:0]        b_data_in,
  output logic [7:0]        data_out,
  output logic              data_out_ready,
  output logic [ADDR_W:0]   fifo_level,
  output logic              busy,
  output logic              overflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state;
  logic [23:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [23:0]         hold;
  logic [1:0]          byte_idx;
  logic [15:0]         gap_cnt;

  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push;
  logic                gap_done;
  logic [23:0]         head;

  // Byte order on the wire is R, G, B; the pixel is stored as {R,G,B}.
  function automatic logic [7:0] byte_sel(input logic [23:0] px, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = px[23:16];
      2'd1:    b = px[15:8];
      default: b = px[7:0];
    endcase
    return b;
  endfunction

  assign fifo_full  = (fifo_level == DEPTH_L);
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr];
  assign pop        = (state == IDLE) && !fifo_empty;
  // A full FIFO still accepts a pixel when the FSM frees a slot in the same cycle.
  assign push       = data_in_valid && (!fifo_full || pop);
  assign gap_done   = (gap_cnt == (BYTE_GAP - 16'd1));

  // Storage has no reset: contents are only visible through fifo_level-qualified pops.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= {r_data_in, g_data_in, b_data_in};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (data_in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Serializer FSM. data_out/data_out_ready are loaded on the edge that enters
  // SEND, so the strobe is high exactly during the SEND cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      hold           <= '0;
      byte_idx       <= '0;
      gap_cnt        <= '0;
      data_out       <= '0;
      data_out_ready <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_out_ready <= 1'b0;
      // Registered from current state, so busy trails the FSM by one cycle.
      busy           <= (state != IDLE) || !fifo_empty;
      case (state)
        IDLE: begin
          if (pop) begin
            hold           <= head;
            byte_idx       <= 2'd0;
            data_out       <= byte_sel(head, 2'd0);
            data_out_ready <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_done) begin
            if (byte_idx == 2'd2) begin
              state <= IDLE;
            end else begin
              byte_idx       <= byte_idx + 2'd1;
              data_out       <= byte_sel(hold, byte_idx + 2'd1);
              data_out_ready <= 1'b1;
              state          <= SEND;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_tx_serializer.sv
// Purpose: scoreboard bench for rgb_tx_serializer (ADDR_W=2, BYTE_GAP=4).
// Latency: checks strobe cycles relative to the pixel write cycle.
// Backpressure: exercises FIFO-full drop, full-with-pop accept, and mid-pixel reset.

module tb_rgb_tx_serializer;

  localparam int          ADDR_W = 2;
  localparam logic [15:0] GAP_P  = 16'd4;
  localparam int          G      = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              data_in_valid;
  logic [7:0]        r_data_in;
  logic [7:0]        g_data_in;
  logic [7:0]        b_data_in;
  logic [7:0]        data_out;
  logic              data_out_ready;
  logic [ADDR_W:0]   fifo_level;
  logic              busy;
  logic              overflow;

  rgb_tx_serializer #(
    .ADDR_W   (ADDR_W),
    .BYTE_GAP (GAP_P)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .data_in_valid  (data_in_valid),
    .r_data_in      (r_data_in),
    .g_data_in      (g_data_in),
    .b_data_in      (b_data_in),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .fifo_level     (fifo_level),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         sq[$];
  int         peak;
  bit         prev_strobe = 1'b0;
  int         t0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every strobe must match the oldest expected byte.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (data_out_ready) begin
        check_val("no_back_to_back", 32'(prev_strobe), 32'd0);
        sq.push_back(cyc);
        if (exp_q.size() == 0) check_val("extra_strobe", 32'd1, 32'd0);
        else                   check_val("byte", 32'(data_out), 32'(exp_q.pop_front()));
      end
      prev_strobe = data_out_ready;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic drive_px(input logic [23:0] px, input bit acc);
    data_in_valid = 1'b1;
    {r_data_in, g_data_in, b_data_in} = px;
    if (acc) begin
      exp_q.push_back(px[23:16]);
      exp_q.push_back(px[15:8]);
      exp_q.push_back(px[7:0]);
    end
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    data_in_valid = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_until(input int c);
    data_in_valid = 1'b0;
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic drain(input string tag);
    int lim;
    lim = 0;
    data_in_valid = 1'b0;
    while (exp_q.size() != 0 && lim < 2000) begin
      @(negedge sys_clk);
      lim++;
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
    repeat (2 * G + 6) @(negedge sys_clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_val({tag, "_ready"},    32'(data_out_ready), 32'd0);
    check_val({tag, "_level"},    32'(fifo_level), 32'd0);
    check_val({tag, "_busy"},     32'(busy), 32'd0);
    check_val({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset();
    data_in_valid = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    exp_q.delete();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] px;
    sys_rst_n     = 1'b0;
    data_in_valid = 1'b0;
    r_data_in     = '0;
    g_data_in     = '0;
    b_data_in     = '0;
    peak          = 0;
    #1;
    check_reset_vals("rst");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 1: single pixel, exact strobe cycles and busy fall time
    sq.delete();
    t0 = cyc;
    drive_px(24'h123456, 1'b1);
    wait_until(t0 + 17);
    check_val("t1_busy_hi", 32'(busy), 32'd1);
    @(negedge sys_clk);
    check_val("t1_busy_lo", 32'(busy), 32'd0);
    drain("t1_drain");
    check_val("t1_nstrobe", 32'(sq.size()), 32'd3);
    if (sq.size() == 3) begin
      check_val("t1_r_cyc", 32'(sq[0] - t0), 32'd2);
      check_val("t1_g_cyc", 32'(sq[1] - t0), 32'd7);
      check_val("t1_b_cyc", 32'(sq[2] - t0), 32'd12);
    end

    // 2: 4-pixel burst, spacing and peak level
    do_reset();
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      px = {8'h10 + 8'(i), 8'h40 + 8'(i), 8'h70 + 8'(i)};
      drive_px(px, 1'b1);
    end
    drain("t2_drain");
    check_val("t2_nstrobe", 32'(sq.size()), 32'd12);
    if (sq.size() == 12) begin
      for (int i = 1; i < 12; i++) begin
        check_val($sformatf("t2_space%0d", i), 32'(sq[i] - sq[i-1]), (i % 3 == 0) ? 32'd6 : 32'd5);
      end
    end
    check_val("t2_peak", 32'(peak), 32'd3);
    check_val("t2_overflow", 32'(overflow), 32'd0);

    // 3: 7-pixel burst, last two dropped
    do_reset();
    for (int i = 0; i < 7; i++) begin
      px = {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i)};
      drive_px(px, i < 5);
    end
    data_in_valid = 1'b0;
    check_val("t3_overflow_set", 32'(overflow), 32'd1);
    drain("t3_drain");
    check_val("t3_nstrobe", 32'(sq.size()), 32'd15);
    idle(20);
    check_val("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: write into a full FIFO on the cycle the FSM pops
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      px = {8'h01 + 8'(i), 8'h11 + 8'(i), 8'h21 + 8'(i)};
      drive_px(px, 1'b1);
    end
    wait_until(t0 + 16);
    check_val("t4_level_full", 32'(fifo_level), 32'd4);
    wait_until(t0 + 17);
    drive_px(24'hE1F203, 1'b1);
    data_in_valid = 1'b0;
    check_val("t4_level_kept", 32'(fifo_level), 32'd4);
    check_val("t4_overflow", 32'(overflow), 32'd0);
    drain("t4_drain");
    check_val("t4_nstrobe", 32'(sq.size()), 32'd18);
    check_val("t4_overflow_end", 32'(overflow), 32'd0);

    // 5: reset during the gap after the G strobe
    do_reset();
    t0 = cyc;
    drive_px(24'h5A6B7C, 1'b1);
    drive_px(24'h0F1E2D, 1'b0);
    wait_until(t0 + 9);
    check_val("t5_pre_strobes", 32'(sq.size()), 32'd2);
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sq.delete();
    idle(3 * G + 10);
    check_val("t5_no_b_strobe", 32'(sq.size()), 32'd0);
    drive_px(24'h9ABCDE, 1'b1);
    drain("t5_drain");
    check_val("t5_nstrobe", 32'(sq.size()), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
